// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind uart_receiver: turns the receiver's level-style
// frame reports into single push/error events, queues good bytes, and counts bad frames.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int ERR_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            Rx_DATA,
    input  logic                  Rx_VALID,
    input  logic                  Rx_FERROR,
    input  logic                  Rx_PERROR,
    input  logic                  clear,
    input  logic                  rd_ready,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [ERR_W-1:0]      err_count
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [ERR_W-1:0]    ERR_MAX    = {ERR_W{1'b1}};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  prev_valid;
    logic                  prev_err;
    logic                  armed;

    logic err_lvl;
    logic push_evt;
    logic err_evt;
    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;

    // armed stays low after reset until Rx_VALID is seen low, so a frame level
    // that straddles reset release is not mistaken for a new frame.
    assign err_lvl  = Rx_FERROR | Rx_PERROR;
    assign push_evt = Rx_VALID & ~prev_valid & armed;
    assign err_evt  = err_lvl & ~prev_err;
    assign push_req = push_evt & ~err_lvl;
    assign pop      = rd_valid & rd_ready;
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign rd_valid = (count != '0);
    assign full     = (count == FULL_COUNT);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_err   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            prev_valid <= Rx_VALID;
            prev_err   <= err_lvl;
            armed      <= armed | ~Rx_VALID;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (err_evt && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    // Storage is not reset; rd_data is only meaningful while rd_valid is high.
    always_ff @(posedge clock) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= Rx_DATA;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of uart_receiver, on the same clock.
- Detects each new frame reported by the receiver and stores error-free bytes in a FIFO.
- Discards errored frames and counts framing/parity errors.
- Presents stored bytes to the host through a valid/ready read port, so the host does not have to catch every byte the moment it arrives.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (depth = 2**DEPTH_LOG2 = 8 entries).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- Rx_DATA  input  8  received byte from uart_receiver.
- Rx_VALID  input  1  level from receiver; high while Rx_DATA holds a good frame.
- Rx_FERROR  input  1  framing error level from receiver.
- Rx_PERROR  input  1  parity error level from receiver.
- clear  input  1  synchronous flush: empties FIFO, zeroes err_count, clears overflow.
- rd_ready  input  1  host accepts rd_data this cycle.
- rd_data  output  8  byte at FIFO head; combinational from head entry.
- rd_valid  output  1  FIFO not empty.
- count  output  DEPTH_LOG2+1  number of stored bytes, 0..8.
- full  output  1  count == 2**DEPTH_LOG2.
- overflow  output  1  sticky; set when a good byte is dropped because the FIFO is full.
- err_count  output  ERR_W  number of errored frames; saturates at 255.

Behaviour:
- Reset (asynchronous): read/write pointers = 0, count = 0, rd_valid = 0, full = 0, overflow = 0, err_count = 0, edge registers = 0. rd_data is don't-care (memory is not reset).
- Edge detect: registers prev_valid and prev_err sample Rx_VALID and (Rx_FERROR | Rx_PERROR) every cycle.
  - push_evt = Rx_VALID & ~prev_valid.
  - err_evt = (Rx_FERROR | Rx_PERROR) & ~prev_err.
  - A level held high for many cycles yields exactly one event.
- Error frames:
  - An err_evt increments err_count by 1, saturating at 2**ERR_W-1.
  - A push_evt in the same cycle as Rx_FERROR or Rx_PERROR high is not written.
- Push:
  - Condition: push_evt & ~(Rx_FERROR | Rx_PERROR).
  - If the FIFO is not full, or a pop occurs in the same cycle, Rx_DATA is written at wr_ptr and wr_ptr increments.
  - Otherwise the byte is dropped and overflow is set to 1.
- Latency: a push sampled at edge k makes the byte visible on rd_data/rd_valid after edge k (cycle k+1).
- Pop:
  - Condition: rd_valid & rd_ready at an edge; rd_ptr increments.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
- Simultaneous push and pop: count is unchanged.
  - When full, the push is accepted; no overflow.
  - When empty, no pop occurs (rd_valid=0); the push is accepted and count goes 0 to 1.
- Pointers are DEPTH_LOG2 bits and wrap 7 to 0 naturally. count is kept as an explicit register updated +1/-1/0.
- clear has priority over push, pop and err_evt in the same cycle:
  - Pointers, count, overflow and err_count go to 0.
  - Edge registers still update, so a level high across clear does not re-trigger afterwards.
- rd_ready while empty: no effect; no underflow, pointers unchanged.
- Reset asserted mid-operation: all state returns immediately to reset values. A Rx_VALID level still high at reset deassertion is not pushed until it falls and rises again.

Test Plan:
- Reset, then Rx_VALID high for 20 cycles with Rx_DATA=8'hA5, rd_ready=0 -> count=1, rd_valid=1, rd_data=8'hA5; a single push only.
- Push bytes 8'h01..8'h0A (10 pulses), rd_ready=0 -> after 8 pushes full=1, count=8; overflow=1 after the 9th; then rd_ready=1 drains 8'h01..8'h08 in order, count returns to 0, overflow stays 1.
- Frame with Rx_VALID and Rx_PERROR both high (Rx_DATA=8'h3C), then a frame with Rx_FERROR only -> no push (count=0), err_count=2.
- FIFO full (8 entries), rd_ready=1 in the same cycle as a push of 8'hFF -> count stays 8, overflow=0, 8'hFF read out last after a full drain; also exercises pointer wrap.
- 300 err_evt pulses -> err_count saturates at 8'hFF; then clear=1 for one cycle with a simultaneous push -> count=0, err_count=0, overflow=0, no byte stored.
- Asynchronous reset asserted mid-stream with count=5 and no clock edge -> all outputs drop to reset values immediately; Rx_VALID held high through reset release -> no push until it toggles.
